// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Arbitration is
// round-robin. The winner's opcode and operands are driven onto the ALU, and the
// ALU result is captured into a single result slot. The slot owner reads the
// result back through a valid/ready response channel.
//
// Ports
//   clk, reset_n                 clock and synchronous active-low reset
//   rX_valid / rX_ready          request handshake (X = 0, 1)
//   rX_opcode, rX_left/right     request payload
//   rX_rvalid / rX_rready        response handshake
//   rX_result                    registered result (meaningful with rX_rvalid)
//   alu_opcode, alu_left/right   drive to the shared ALU
//   alu_result                   ALU output, only ever seen through result_q
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,

   input  logic             r0_valid,
   input  logic [2:0]       r0_opcode,
   input  logic [WIDTH-1:0] r0_left,
   input  logic [WIDTH-1:0] r0_right,
   output logic             r0_ready,
   output logic             r0_rvalid,
   output logic [WIDTH-1:0] r0_result,
   input  logic             r0_rready,

   input  logic             r1_valid,
   input  logic [2:0]       r1_opcode,
   input  logic [WIDTH-1:0] r1_left,
   input  logic [WIDTH-1:0] r1_right,
   output logic             r1_ready,
   output logic             r1_rvalid,
   output logic [WIDTH-1:0] r1_result,
   input  logic             r1_rready,

   output logic [2:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_left,
   output logic [WIDTH-1:0] alu_right,
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic {
      IDLE = 1'b0,   // result slot empty
      HOLD = 1'b1    // result slot full, owned by owner_q
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             prio_q,  prio_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             owner_rready;
   logic             slot_free;
   logic             grant;
   logic             winner;

   // Arbitration, ALU drive and next state.
   always_comb begin
      owner_rready = owner_q ? r1_rready : r0_rready;
      // The slot is reusable in the same cycle its owner drains it,
      // which gives back-to-back throughput.
      slot_free    = (state_q == IDLE) || owner_rready;

      grant  = 1'b0;
      winner = 1'b0;
      // Gating on reset_n keeps both readys low while reset is held.
      if (reset_n && slot_free) begin
         if (r0_valid && r1_valid) begin
            grant  = 1'b1;
            winner = prio_q;
         end else if (r0_valid) begin
            grant  = 1'b1;
            winner = 1'b0;
         end else if (r1_valid) begin
            grant  = 1'b1;
            winner = 1'b1;
         end
      end

      r0_ready = grant && !winner;
      r1_ready = grant &&  winner;

      alu_opcode = 3'd0;
      alu_left   = '0;
      alu_right  = '0;
      if (grant) begin
         if (winner) begin
            alu_opcode = r1_opcode;
            alu_left   = r1_left;
            alu_right  = r1_right;
         end else begin
            alu_opcode = r0_opcode;
            alu_left   = r0_left;
            alu_right  = r0_right;
         end
      end

      state_d  = state_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      result_d = result_q;
      if (grant) begin
         state_d  = HOLD;
         owner_d  = winner;
         prio_d   = !winner;
         result_d = alu_result;
      end else if ((state_q == HOLD) && owner_rready) begin
         state_d  = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         prio_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
         result_q <= result_d;
      end
   end

   assign r0_rvalid = (state_q == HOLD) && !owner_q;
   assign r1_rvalid = (state_q == HOLD) &&  owner_q;
   assign r0_result = result_q;
   assign r1_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. The bench contains a behavioural ALU
// (ADD, AND, everything else yields 0). Inputs change 1 ns after the rising
// edge. Outputs are sampled 1 ns after the inputs change, well before the
// next edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
   logic [2:0]  r0_opcode;
   logic [31:0] r0_left, r0_right, r0_result;
   logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
   logic [2:0]  r1_opcode;
   logic [31:0] r1_left, r1_right, r1_result;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_left, alu_right, alu_result;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .r0_valid   (r0_valid),
      .r0_opcode  (r0_opcode),
      .r0_left    (r0_left),
      .r0_right   (r0_right),
      .r0_ready   (r0_ready),
      .r0_rvalid  (r0_rvalid),
      .r0_result  (r0_result),
      .r0_rready  (r0_rready),
      .r1_valid   (r1_valid),
      .r1_opcode  (r1_opcode),
      .r1_left    (r1_left),
      .r1_right   (r1_right),
      .r1_ready   (r1_ready),
      .r1_rvalid  (r1_rvalid),
      .r1_result  (r1_result),
      .r1_rready  (r1_rready),
      .alu_opcode (alu_opcode),
      .alu_left   (alu_left),
      .alu_right  (alu_right),
      .alu_result (alu_result)
   );

   // Shared ALU
   always_comb begin
      case (alu_opcode)
         3'd0:    alu_result = alu_left + alu_right;
         3'd7:    alu_result = alu_left & alu_right;
         default: alu_result = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive0(input logic v, input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
      r0_valid = v; r0_opcode = op; r0_left = l; r0_right = r;
   endtask

   task automatic drive1(input logic v, input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
      r1_valid = v; r1_opcode = op; r1_left = l; r1_right = r;
   endtask

   // Tables for the alternating-grant test
   logic [2:0]  t0_op  [2] = '{3'd0, 3'd0};
   logic [31:0] t0_l   [2] = '{32'd1, 32'd10};
   logic [31:0] t0_r   [2] = '{32'd2, 32'd20};
   logic [31:0] t0_exp [2] = '{32'd3, 32'd30};
   logic [2:0]  t1_op  [2] = '{3'd7, 3'd0};
   logic [31:0] t1_l   [2] = '{32'h0000F0F0, 32'h80000000};
   logic [31:0] t1_r   [2] = '{32'h0000FF00, 32'h80000000};
   logic [31:0] t1_exp [2] = '{32'h0000F000, 32'h00000000};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int i0, i1, w;

      // ---------------- reset ----------------
      reset_n = 1'b0;
      r0_rready = 1'b0; r1_rready = 1'b0;
      drive0(1'b1, 3'd0, 32'd1, 32'd1);
      drive1(1'b1, 3'd0, 32'd1, 32'd1);
      step(); step();
      check("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
      check("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
      check("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      check("rst_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
      check("rst_result", r0_result, 32'd0);

      // ---------------- r0 ADD 5+7 ----------------
      reset_n = 1'b1;
      drive0(1'b1, 3'd0, 32'd5, 32'd7);
      drive1(1'b0, 3'd0, 32'd0, 32'd0);
      r0_rready = 1'b1;
      settle();
      check("add_r0_ready", {31'd0, r0_ready}, 32'd1);
      check("add_r1_ready", {31'd0, r1_ready}, 32'd0);
      check("add_alu_left", alu_left, 32'd5);
      step();
      drive0(1'b0, 3'd0, 32'd0, 32'd0);
      settle();
      check("add_r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
      check("add_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
      check("add_result", r0_result, 32'd12);
      step();
      check("add_idle_rvalid", {31'd0, r0_rvalid}, 32'd0);
      check("idle_alu_opcode", {29'd0, alu_opcode}, 32'd0);
      check("idle_alu_left", alu_left, 32'd0);
      r0_rready = 1'b0;

      // ---------------- r1 AND / opcode 3 / wrap ADD ----------------
      drive1(1'b1, 3'd7, 32'hFF00FF00, 32'h0F0F0F0F);
      settle();
      check("and_r1_ready", {31'd0, r1_ready}, 32'd1);
      step();
      drive1(1'b0, 3'd0, 32'd0, 32'd0);
      settle();
      check("and_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
      check("and_result", r1_result, 32'h0F000F00);
      step();   // result stays pending (r1_rready low)
      check("and_held", r1_result, 32'h0F000F00);
      r1_rready = 1'b1;
      drive1(1'b1, 3'd3, 32'hA5A5A5A5, 32'h5A5A5A5A);
      settle();
      check("op3_b2b_ready", {31'd0, r1_ready}, 32'd1);
      step();
      check("op3_rvalid", {31'd0, r1_rvalid}, 32'd1);
      check("op3_result", r1_result, 32'h00000000);
      drive1(1'b1, 3'd0, 32'h00000010, 32'h00000020);
      step();
      check("add30_result", r1_result, 32'h00000030);
      drive1(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000001);
      step();
      check("wrap_rvalid", {31'd0, r1_rvalid}, 32'd1);
      check("wrap_result", r1_result, 32'h00000000);
      drive1(1'b0, 3'd0, 32'd0, 32'd0);
      step();
      check("wrap_idle", {31'd0, r1_rvalid}, 32'd0);

      // ---------------- alternating grants ----------------
      r0_rready = 1'b1; r1_rready = 1'b1;
      i0 = 0; i1 = 0;
      for (int k = 0; k < 4; k++) begin
         if (i0 < 2) drive0(1'b1, t0_op[i0], t0_l[i0], t0_r[i0]);
         else        drive0(1'b0, 3'd0, 32'd0, 32'd0);
         if (i1 < 2) drive1(1'b1, t1_op[i1], t1_l[i1], t1_r[i1]);
         else        drive1(1'b0, 3'd0, 32'd0, 32'd0);
         settle();
         w = k % 2;
         check($sformatf("alt%0d_r0_ready", k), {31'd0, r0_ready}, (w == 0) ? 32'd1 : 32'd0);
         check($sformatf("alt%0d_r1_ready", k), {31'd0, r1_ready}, (w == 1) ? 32'd1 : 32'd0);
         step();
         if (w == 0) begin
            check($sformatf("alt%0d_r0_rvalid", k), {31'd0, r0_rvalid}, 32'd1);
            check($sformatf("alt%0d_r1_rvalid", k), {31'd0, r1_rvalid}, 32'd0);
            check($sformatf("alt%0d_result", k), r0_result, t0_exp[i0]);
            i0++;
         end else begin
            check($sformatf("alt%0d_r1_rvalid", k), {31'd0, r1_rvalid}, 32'd1);
            check($sformatf("alt%0d_r0_rvalid", k), {31'd0, r0_rvalid}, 32'd0);
            check($sformatf("alt%0d_result", k), r1_result, t1_exp[i1]);
            i1++;
         end
      end
      drive0(1'b0, 3'd0, 32'd0, 32'd0);
      drive1(1'b0, 3'd0, 32'd0, 32'd0);
      step();
      check("alt_idle_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);

      // ---------------- backpressure ----------------
      r0_rready = 1'b0; r1_rready = 1'b0;
      drive0(1'b1, 3'd0, 32'd40, 32'd2);
      step();
      drive0(1'b0, 3'd0, 32'd0, 32'd0);
      drive1(1'b1, 3'd7, 32'hFFFFFFFF, 32'h12345678);
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("bp%0d_r1_ready", k), {31'd0, r1_ready}, 32'd0);
         check($sformatf("bp%0d_r0_rvalid", k), {31'd0, r0_rvalid}, 32'd1);
         check($sformatf("bp%0d_result", k), r0_result, 32'd42);
         step();
      end
      r0_rready = 1'b1;
      settle();
      check("bp_release_r1_ready", {31'd0, r1_ready}, 32'd1);
      step();
      r0_rready = 1'b0;
      drive1(1'b0, 3'd0, 32'd0, 32'd0);
      settle();
      check("bp_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
      check("bp_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      check("bp_r1_result", r1_result, 32'h12345678);

      // ---------------- reset mid-HOLD (r1 owner) ----------------
      reset_n = 1'b0;
      drive0(1'b1, 3'd0, 32'd3, 32'd4);
      drive1(1'b1, 3'd7, 32'hFFFF0000, 32'h00FF00FF);
      settle();
      check("hrst_r0_ready", {31'd0, r0_ready}, 32'd0);
      check("hrst_r1_ready", {31'd0, r1_ready}, 32'd0);
      step();
      check("hrst_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
      check("hrst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      check("hrst_result", r1_result, 32'd0);
      reset_n = 1'b1;
      settle();
      check("post_rst_r0_ready", {31'd0, r0_ready}, 32'd1);
      check("post_rst_r1_ready", {31'd0, r1_ready}, 32'd0);
      step();
      check("post_rst_result", r0_result, 32'd7);

      // prio is now 1; another reset must return it to 0
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      settle();
      check("prio_rst_r0_ready", {31'd0, r0_ready}, 32'd1);
      check("prio_rst_r1_ready", {31'd0, r1_ready}, 32'd0);
      step();
      check("prio_rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
      check("prio_rst_result", r0_result, 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
